// File: rtl/data_mem_responder_pkg.sv
// Shared data-bus definitions: access-size encodings, responder FSM states
// and the latched request record.
package mem_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering: byte enables, store merge over the old
// word, and right-justified zero-extended load data.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word,
  output logic [31:0] load_word
);

  logic [1:0]  lane_s;
  logic [31:0] repl_s;
  logic [31:0] shifted_s;

  // Lane select and store-data replication; unaligned low bits are dropped
  always_comb begin
    byte_en = 4'b1111;
    lane_s  = 2'b00;
    repl_s  = store_data;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        lane_s  = addr_lo;
        repl_s  = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_s  = {addr_lo[1], 1'b0};
        repl_s  = {2{store_data[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        lane_s  = 2'b00;
        repl_s  = store_data;
      end
    endcase
  end

  // Enabled lanes take store data, the rest keep the current word
  always_comb begin
    merged_word = mem_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = repl_s[8*i +: 8];
      end else begin
        merged_word[8*i +: 8] = mem_word[8*i +: 8];
      end
    end
  end

  assign shifted_s = mem_word >> {lane_s, 3'b000};

  // Zero-extend; sign extension is the core's job
  always_comb begin
    load_word = shifted_s;
    case (size)
      SZ_BYTE: load_word = {24'h000000, shifted_s[7:0]};
      SZ_HALF: load_word = {16'h0000, shifted_s[15:0]};
      default: load_word = shifted_s;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Reference data memory for the core's data bus: wait-stated active-low
// acknowledge, little-endian byte-addressed word array, tri-state DDT.
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]    state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  mem_req_t      req_r, cur_req_s;
  logic          latch_s, enter_ack_s;
  logic          ack_n_r, drive_r;
  logic [31:0]   rdata_r;
  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [AW-1:0] word_idx_s;
  logic [31:0]   mem_word_s, merged_s, load_word_s;
  logic [3:0]    byte_en_s;
  logic          unused_addr_s;

  // In IDLE the bus itself is the request, so a zero-wait access can commit
  // on the same edge that latches it
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_req_s = {WRITE, SIZE, DAD, DDT};
    end else begin
      cur_req_s = req_r;
    end
  end

  assign word_idx_s    = cur_req_s.addr[2 +: AW];
  assign mem_word_s    = mem_r[word_idx_s];
  assign unused_addr_s = ^cur_req_s.addr[31:AW+2];

  mem_lane_align u_align (
    .size        (cur_req_s.size),
    .addr_lo     (cur_req_s.addr[1:0]),
    .store_data  (cur_req_s.wdata),
    .mem_word    (mem_word_s),
    .byte_en     (byte_en_s),
    .merged_word (merged_s),
    .load_word   (load_word_s)
  );

  // Next-state logic; a dropped MREQ in WAIT aborts before any commit
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    enter_ack_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MREQ) begin
          latch_s = 1'b1;
          if (WAIT_LOAD == 4'd0) begin
            state_nxt_s = ST_ACK;
            enter_ack_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!MREQ) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          state_nxt_s = ST_ACK;
          cnt_nxt_s   = 4'd0;
          enter_ack_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!MREQ) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // FSM, counter, request latch and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      req_r   <= '0;
      ack_n_r <= 1'b1;
      drive_r <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_n_r <= ~enter_ack_s;
      drive_r <= enter_ack_s & ~cur_req_s.write;
      if (latch_s) begin
        req_r <= cur_req_s;
      end
      if (enter_ack_s) begin
        rdata_r <= load_word_s;
      end
    end
  end

  // Store commits on the ACK-entry edge; the array is never reset
  always_ff @(posedge clk) begin
    if (!rst && enter_ack_s && cur_req_s.write && (|byte_en_s)) begin
      mem_r[word_idx_s] <= merged_s;
    end
  end

  assign ACKD_n = ack_n_r;
  // Live WRITE gate keeps us off the bus whenever the core is driving it
  assign DDT = (drive_r && !WRITE) ? rdata_r : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed accesses push expected
// acknowledge cycle and data; a negedge monitor pops and compares.
module tb_data_mem_responder;
  import mem_bus_pkg::*;

  localparam int WAITC = 1;

  typedef struct {
    int unsigned cyc;
    logic        load;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mreq = 1'b0, write = 1'b0;
  logic [1:0]  size = SZ_WORD;
  logic [31:0] dad = 32'h0;
  wire  [31:0] ddt;
  logic        ackd_n;
  // Probe driver: the bench holds DDT at tb_dat whenever the DUT must be off
  // the bus; it only lets go during a load's acknowledge cycle
  logic        tb_drv = 1'b1, tb_rel = 1'b1;
  logic [31:0] tb_dat = 32'h0;
  assign ddt = (tb_drv && !(tb_rel && !ackd_n)) ? tb_dat : 32'hzzzz_zzzz;

  logic        mreq0 = 1'b0;
  wire  [31:0] ddt0;
  logic        ackd0_n;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .rst(rst), .MREQ(mreq), .WRITE(write), .SIZE(size),
    .DAD(dad), .DDT(ddt), .ACKD_n(ackd_n)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .MREQ(mreq0), .WRITE(1'b0), .SIZE(SZ_WORD),
    .DAD(32'h0000_0010), .DDT(ddt0), .ACKD_n(ackd0_n)
  );

  int unsigned cyc = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  logic post_chk = 1'b0;
  int ack0_cnt = 0;
  int unsigned first_ack0 = 0, last_ack0 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the main instance
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      post_chk = 1'b0;
    end else begin
      if (post_chk) begin
        check("ack_width", {31'h0, ackd_n}, 32'h1);
        check("ddt_release", ddt, tb_dat);
        post_chk = 1'b0;
      end
      if (sb.size() > 0 && sb[0].load && cyc + 1 == sb[0].cyc)
        check("ddt_pre_z", ddt, 32'h0);
      if (!ackd_n) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {31'h0, ackd_n}, 32'h1);
        end else begin
          e = sb.pop_front();
          check("ack_latency", cyc, e.cyc);
          if (e.load) check("load_data", ddt, e.data);
          else check("store_no_drive", ddt, tb_dat);
          post_chk = 1'b1;
        end
      end
    end
  end

  // Monitor for the zero-wait instance
  initial forever begin
    @(negedge clk);
    if (!rst && !ackd0_n) begin
      if (ack0_cnt == 0) first_ack0 = cyc;
      last_ack0 = cyc;
      ack0_cnt++;
    end
  end

  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ackd_n) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: ACKD_n stayed 1, required 0");
  endtask

  task automatic start_req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk); #1;
    mreq = 1'b1; write = wr; size = sz; dad = a;
    tb_rel = !wr; tb_dat = wr ? d : 32'h0;
    e.cyc = cyc + WAITC + 1; e.load = !wr; e.data = exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble the bus after the latch edge
    dad = ~a; size = ~sz;
    if (wr) tb_dat = ~d;
  endtask

  task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    start_req(wr, sz, a, d, exp_rd);
    wait_ack();
    @(posedge clk); #1;
    mreq = 1'b0; write = 1'b0; tb_dat = 32'h0; tb_rel = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input logic use_rst);
    @(posedge clk); #1;
    mreq = 1'b1; write = 1'b1; size = SZ_WORD; dad = a; tb_rel = 1'b0; tb_dat = d;
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    mreq = 1'b0; write = 1'b0; tb_dat = 32'h0; tb_rel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ackd_n", {31'h0, ackd_n}, 32'h1);
    check("reset_ddt_z", ddt, 32'h0);
    rst = 1'b0;

    // Preload word 0, then show a reset leaves it intact
    access(1'b1, SZ_WORD, 32'h0000_0000, 32'h1234_5678, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("reset_ack_mid", {31'h0, ackd_n}, 32'h1);
    rst = 1'b0;
    access(1'b0, SZ_WORD, 32'h0000_0000, 32'h0, 32'h1234_5678);

    access(1'b1, SZ_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
    access(1'b1, SZ_BYTE, 32'h0000_0101, 32'hFFFF_FF5A, 32'h0);
    access(1'b0, SZ_WORD, 32'h0000_0100, 32'h0, 32'hDEAD_5AEF);
    access(1'b0, SZ_HALF, 32'h0000_0102, 32'h0, 32'h0000_DEAD);
    access(1'b0, SZ_HALF, 32'h0000_0103, 32'h0, 32'h0000_DEAD);
    access(1'b0, SZ_BYTE, 32'h0000_0103, 32'h0, 32'h0000_00DE);
    access(1'b0, SZ_BYTE, 32'h0000_0101, 32'h0, 32'h0000_005A);

    access(1'b1, SZ_WORD, 32'h0000_0104, 32'h1122_3344, 32'h0);
    access(1'b1, SZ_HALF, 32'h0000_0107, 32'hFFFF_A5C3, 32'h0);
    access(1'b0, SZ_WORD, 32'h0000_0104, 32'h0, 32'hA5C3_3344);
    access(1'b0, SZ_HALF, 32'h0000_0104, 32'h0, 32'h0000_3344);
    access(1'b0, 2'b11,   32'h0000_0106, 32'h0, 32'hA5C3_3344);

    // 4*1024+8 aliases to word index 2
    access(1'b1, SZ_WORD, 32'h0000_1008, 32'hCAFE_F00D, 32'h0);
    access(1'b0, SZ_WORD, 32'h0000_0008, 32'h0, 32'hCAFE_F00D);

    abort_store(32'h0000_0100, 32'h0BAD_0BAD, 1'b0);
    access(1'b0, SZ_WORD, 32'h0000_0100, 32'h0, 32'hDEAD_5AEF);
    abort_store(32'h0000_0104, 32'h0BAD_0BAD, 1'b1);
    access(1'b0, SZ_WORD, 32'h0000_0104, 32'h0, 32'hA5C3_3344);

    // Reset during ACK: the store has already committed
    start_req(1'b1, SZ_WORD, 32'h0000_010C, 32'h600D_F00D, 32'h0);
    wait_ack();
    #1;
    rst = 1'b1; mreq = 1'b0; write = 1'b0; tb_dat = 32'h0; tb_rel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    access(1'b0, SZ_WORD, 32'h0000_010C, 32'h0, 32'h600D_F00D);

    // Zero-wait instance: MREQ held high yields a single acknowledge
    @(posedge clk); #1;
    mreq0 = 1'b1;
    last_ack0 = cyc + 1;
    repeat (6) @(posedge clk);
    #1;
    check("w0_latency", first_ack0, last_ack0);
    check("w0_single_ack", ack0_cnt, 32'd1);
    mreq0 = 1'b0;
    @(posedge clk); #1;
    mreq0 = 1'b1;
    first_ack0 = cyc + 1;
    repeat (4) @(posedge clk);
    #1;
    check("w0_second_ack", ack0_cnt, 32'd2);
    check("w0_latency2", last_ack0, first_ack0);
    mreq0 = 1'b0;

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
